delay_timer: RTL and testbench

Programmable one-shot delay timer that answers the `START`/`RDY` handshake issued by the team's Moore sequencing FSMs. A one-cycle `START` pulse loads a tick count and drops `RDY`. The block counts prescaled ticks down to zero, then raises `RDY` and holds it until the next `START`. It sits beside each sequencer as its timing responder, with `START` and `RDY` wired point-to-point.

---
 rtl/delay_timer.sv | 61 ++++++
 tb/tb_delay_timer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/delay_timer.sv
// delay_timer: one-shot prescaled delay timer answering the START/RDY handshake
module delay_timer #(
  parameter int PRESCALE = 50000,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             START,
  input  logic [WIDTH-1:0] TICKS,
  input  logic             CANCEL,
  output logic             RDY,
  output logic             BUSY,
  output logic [WIDTH-1:0] REMAIN
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic wrap;
  assign wrap = pre == PMAX;
  // state, prescaler and remaining-tick registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      pre    <= '0;
      REMAIN <= '0;
    end else begin
      state  <= state_nxt;
      pre    <= pre_nxt;
      REMAIN <= rem_nxt;
    end
  // cancel beats start beats counting; a tick is consumed on each prescaler wrap
  always_comb begin
    state_nxt = state;
    pre_nxt = pre;
    rem_nxt = REMAIN;
    if (CANCEL) begin
      state_nxt = IDLE;
      pre_nxt = '0;
      rem_nxt = '0;
    end else if (START) begin
      state_nxt = RUN;
      pre_nxt = '0;
      rem_nxt = TICKS;
    end else if (state == RUN) begin
      if (REMAIN == '0) state_nxt = DONE;
      else begin
        pre_nxt = wrap ? '0 : pre + PW'(1);
        rem_nxt = wrap ? REMAIN - WIDTH'(1) : REMAIN;
        state_nxt = (wrap && REMAIN == WIDTH'(1)) ? DONE : RUN;
      end
    end
  end
  // handshake outputs decoded from the registered state
  always_comb begin
    RDY = state == DONE;
    BUSY = state == RUN;
  end
endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: directed self-checking bench for delay_timer
module tb_delay_timer;
  logic clk = 0, reset = 0, START = 0, CANCEL = 0;
  logic [7:0] TICKS = 0;
  logic RDY, BUSY;
  logic [7:0] REMAIN;
  int checks = 0, errors = 0;

  delay_timer #(.PRESCALE(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .START(START), .TICKS(TICKS), .CANCEL(CANCEL),
    .RDY(RDY), .BUSY(BUSY), .REMAIN(REMAIN)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] t);
    START = 1;
    TICKS = t;
    step(1);
    START = 0;
  endtask

  task automatic wait_rdy(output int n, input int limit);
    n = 0;
    while (!RDY && n < limit) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n, bad;
    logic [7:0] prev;
    step(2);
    check("reset_rdy", RDY, 0);
    check("reset_busy", BUSY, 0);
    check("reset_remain", REMAIN, 0);
    reset = 1;
    step(1);

    pulse_start(5);
    step(3);
    check("run_busy", BUSY, 1);
    reset = 0;
    #2;
    check("async_rdy", RDY, 0);
    check("async_busy", BUSY, 0);
    check("async_remain", REMAIN, 0);
    step(1);
    reset = 1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (RDY) bad++;
    end
    check("post_reset_no_rdy", bad, 0);

    pulse_start(3);
    for (int i = 0; i < 12; i++) begin
      check("basic_busy", BUSY, 1);
      check("basic_rdy_low", RDY, 0);
      check("basic_remain", REMAIN, 3 - i / 4);
      step(1);
    end
    check("basic_rdy", RDY, 1);
    check("basic_busy_end", BUSY, 0);
    check("basic_remain_end", REMAIN, 0);
    step(5);
    check("basic_rdy_hold", RDY, 1);

    pulse_start(0);
    check("zero_busy", BUSY, 1);
    check("zero_rdy_low", RDY, 0);
    step(1);
    check("zero_rdy", RDY, 1);
    check("zero_busy_end", BUSY, 0);

    pulse_start(255);
    check("max_remain", REMAIN, 255);
    n = 0;
    bad = 0;
    prev = REMAIN;
    while (!RDY && n < 2000) begin
      step(1);
      n++;
      if (REMAIN > prev) bad++;
      prev = REMAIN;
    end
    check("max_delay", n, 1020);
    check("max_no_wrap", bad, 0);
    check("max_remain_end", REMAIN, 0);

    pulse_start(5);
    step(5);
    pulse_start(2);
    check("retrig_remain", REMAIN, 2);
    wait_rdy(n, 100);
    check("retrig_delay", n, 8);

    pulse_start(4);
    step(4);
    CANCEL = 1;
    step(1);
    CANCEL = 0;
    check("cancel_rdy", RDY, 0);
    check("cancel_busy", BUSY, 0);
    check("cancel_remain", REMAIN, 0);
    START = 1;
    CANCEL = 1;
    TICKS = 7;
    step(1);
    START = 0;
    CANCEL = 0;
    check("both_busy", BUSY, 0);
    check("both_rdy", RDY, 0);
    check("both_remain", REMAIN, 0);

    for (int t = 1; t <= 10; t++) begin
      pulse_start(8'(t));
      check("hs_rdy_after_start", RDY, 0);
      wait_rdy(n, 100);
      check("hs_wait", n, t * 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
